// File: rtl/lsu_pkg.sv
// Shared definitions for the memory-stage load/store unit.
// Bit positions of load_store_info, FSM states, access sizes and the op decoder.
package lsu_pkg;

    // load_store_info = {lb,lh,lw,ld,lbu,lhu,lwu,sb,sh,sw,sd}
    localparam int LS_W   = 11;
    localparam int LS_LB  = 10;
    localparam int LS_LH  = 9;
    localparam int LS_LW  = 8;
    localparam int LS_LD  = 7;
    localparam int LS_LBU = 6;
    localparam int LS_LHU = 5;
    localparam int LS_LWU = 4;
    localparam int LS_SB  = 3;
    localparam int LS_SH  = 2;
    localparam int LS_SW  = 1;
    localparam int LS_SD  = 0;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_REQ  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    localparam logic [1:0] SZ_B = 2'd0;
    localparam logic [1:0] SZ_H = 2'd1;
    localparam logic [1:0] SZ_W = 2'd2;
    localparam logic [1:0] SZ_D = 2'd3;

    typedef struct packed {
        logic       valid;
        logic       load;
        logic       store;
        logic       sign;
        logic [1:0] size;
    } ls_dec_t;

    function automatic ls_dec_t ls_decode(input logic [LS_W-1:0] info);
        ls_dec_t d;
        d = '0;
        unique case (1'b1)
            info[LS_LB]:  d = '{1'b1, 1'b1, 1'b0, 1'b1, SZ_B};
            info[LS_LH]:  d = '{1'b1, 1'b1, 1'b0, 1'b1, SZ_H};
            info[LS_LW]:  d = '{1'b1, 1'b1, 1'b0, 1'b1, SZ_W};
            info[LS_LD]:  d = '{1'b1, 1'b1, 1'b0, 1'b0, SZ_D};
            info[LS_LBU]: d = '{1'b1, 1'b1, 1'b0, 1'b0, SZ_B};
            info[LS_LHU]: d = '{1'b1, 1'b1, 1'b0, 1'b0, SZ_H};
            info[LS_LWU]: d = '{1'b1, 1'b1, 1'b0, 1'b0, SZ_W};
            info[LS_SB]:  d = '{1'b1, 1'b0, 1'b1, 1'b0, SZ_B};
            info[LS_SH]:  d = '{1'b1, 1'b0, 1'b1, 1'b0, SZ_H};
            info[LS_SW]:  d = '{1'b1, 1'b0, 1'b1, 1'b0, SZ_W};
            info[LS_SD]:  d = '{1'b1, 1'b0, 1'b1, 1'b0, SZ_D};
            default:      d = '0;
        endcase
        return d;
    endfunction

    // Natural alignment: low address bits below the access size must be zero.
    function automatic logic ls_misaligned(input logic [1:0] size,
                                           input logic [2:0] off);
        logic m;
        case (size)
            SZ_H:    m = off[0];
            SZ_W:    m = |off[1:0];
            SZ_D:    m = |off;
            default: m = 1'b0;
        endcase
        return m;
    endfunction

endpackage

// File: rtl/lsu_align.sv
// Combinational data steering for the LSU: store lane replication and byte
// strobes (st_*), load lane extraction with sign/zero extension (ld_*).
module lsu_align
    import lsu_pkg::*;
(
    input  logic [1:0]  st_size,
    input  logic [2:0]  st_off,
    input  logic [63:0] st_data,
    output logic [63:0] st_wdata,
    output logic [7:0]  st_wstrb,
    input  logic [1:0]  ld_size,
    input  logic        ld_sign,
    input  logic [2:0]  ld_off,
    input  logic [63:0] ld_rdata,
    output logic [63:0] ld_data
);

    logic [7:0]  strb_base;
    logic [63:0] ld_shift;

    always_comb begin
        st_wdata  = st_data;
        strb_base = 8'hFF;
        case (st_size)
            SZ_B: begin
                st_wdata  = {8{st_data[7:0]}};
                strb_base = 8'h01;
            end
            SZ_H: begin
                st_wdata  = {4{st_data[15:0]}};
                strb_base = 8'h03;
            end
            SZ_W: begin
                st_wdata  = {2{st_data[31:0]}};
                strb_base = 8'h0F;
            end
            default: begin
                st_wdata  = st_data;
                strb_base = 8'hFF;
            end
        endcase
        // Offset is naturally aligned here, so the shift never drops bits.
        st_wstrb = strb_base << st_off;
    end

    always_comb begin
        ld_shift = ld_rdata >> {ld_off, 3'b000};
        case (ld_size)
            SZ_B:    ld_data = {{56{ld_sign & ld_shift[7]}},  ld_shift[7:0]};
            SZ_H:    ld_data = {{48{ld_sign & ld_shift[15]}}, ld_shift[15:0]};
            SZ_W:    ld_data = {{32{ld_sign & ld_shift[31]}}, ld_shift[31:0]};
            default: ld_data = ld_shift;
        endcase
    end

endmodule

// File: rtl/mem_lsu_ctrl.sv
// Memory-stage load/store controller: one req/ack data-cache transaction per
// mem op in regM, stalls the pipe until done, times out to a bus error.
// Ports: regM_i_* (EX/MEM register), dcache_o_*/dcache_i_* (cache handshake),
// lsu_o_* (stall, writeback data, done/misalign/bus_err pulses).
module mem_lsu_ctrl
    import lsu_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 255,
    parameter int TO_W           = 8
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [LS_W-1:0] regM_i_load_store_info,
    input  logic [63:0]     regM_i_alu_result,
    input  logic [63:0]     regM_i_regdata2,
    output logic            dcache_o_req,
    output logic            dcache_o_we,
    output logic [63:0]     dcache_o_addr,
    output logic [63:0]     dcache_o_wdata,
    output logic [7:0]      dcache_o_wstrb,
    input  logic            dcache_i_ack,
    input  logic [63:0]     dcache_i_rdata,
    output logic            lsu_o_stall,
    output logic [63:0]     lsu_o_wb_data,
    output logic            lsu_o_done,
    output logic            lsu_o_misalign,
    output logic            lsu_o_bus_err
);

    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);

    logic [1:0]      state_q, state_d;
    logic [63:0]     addr_q, addr_d;
    logic            we_q, we_d;
    logic [63:0]     wdata_q, wdata_d;
    logic [7:0]      wstrb_q, wstrb_d;
    logic [1:0]      size_q, size_d;
    logic            sign_q, sign_d;
    logic            load_q, load_d;
    logic [2:0]      off_q, off_d;
    logic [TO_W-1:0] cnt_q, cnt_d;
    logic [63:0]     result_q, result_d;
    logic            bus_err_q, bus_err_d;

    ls_dec_t     dec;
    logic        mis;
    logic        start;
    logic [63:0] st_wdata;
    logic [7:0]  st_wstrb;
    logic [63:0] ld_data;

    assign dec   = ls_decode(regM_i_load_store_info);
    assign mis   = dec.valid & ls_misaligned(dec.size, regM_i_alu_result[2:0]);
    assign start = (state_q == ST_IDLE) & dec.valid & ~mis;

    lsu_align u_align (
        .st_size  (dec.size),
        .st_off   (regM_i_alu_result[2:0]),
        .st_data  (regM_i_regdata2),
        .st_wdata (st_wdata),
        .st_wstrb (st_wstrb),
        .ld_size  (size_q),
        .ld_sign  (sign_q),
        .ld_off   (off_q),
        .ld_rdata (dcache_i_rdata),
        .ld_data  (ld_data)
    );

    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        we_d      = we_q;
        wdata_d   = wdata_q;
        wstrb_d   = wstrb_q;
        size_d    = size_q;
        sign_d    = sign_q;
        load_d    = load_q;
        off_d     = off_q;
        cnt_d     = cnt_q;
        result_d  = result_q;
        bus_err_d = 1'b0;
        case (state_q)
            ST_IDLE: begin
                cnt_d = '0;
                if (start) begin
                    addr_d  = {regM_i_alu_result[63:3], 3'b000};
                    we_d    = dec.store;
                    wdata_d = dec.store ? st_wdata : 64'd0;
                    wstrb_d = dec.store ? st_wstrb : 8'd0;
                    size_d  = dec.size;
                    sign_d  = dec.sign;
                    load_d  = dec.load;
                    off_d   = regM_i_alu_result[2:0];
                    state_d = ST_REQ;
                end
            end
            ST_REQ: begin
                cnt_d = cnt_q + 1'b1;
                // Ack has priority over a coincident timeout.
                if (dcache_i_ack) begin
                    result_d = load_q ? ld_data : 64'd0;
                    state_d  = ST_DONE;
                end else if (cnt_q == TO_LAST) begin
                    result_d  = 64'd0;
                    bus_err_d = 1'b1;
                    state_d   = ST_DONE;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            addr_q    <= '0;
            we_q      <= 1'b0;
            wdata_q   <= '0;
            wstrb_q   <= '0;
            size_q    <= SZ_B;
            sign_q    <= 1'b0;
            load_q    <= 1'b0;
            off_q     <= '0;
            cnt_q     <= '0;
            result_q  <= '0;
            bus_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            we_q      <= we_d;
            wdata_q   <= wdata_d;
            wstrb_q   <= wstrb_d;
            size_q    <= size_d;
            sign_q    <= sign_d;
            load_q    <= load_d;
            off_q     <= off_d;
            cnt_q     <= cnt_d;
            result_q  <= result_d;
            bus_err_q <= bus_err_d;
        end
    end

    assign dcache_o_req   = (state_q == ST_REQ);
    assign dcache_o_we    = we_q;
    assign dcache_o_addr  = addr_q;
    assign dcache_o_wdata = wdata_q;
    assign dcache_o_wstrb = wstrb_q;

    assign lsu_o_stall    = start | (state_q == ST_REQ);
    assign lsu_o_done     = (state_q == ST_DONE);
    assign lsu_o_bus_err  = bus_err_q;
    assign lsu_o_misalign = (state_q == ST_IDLE) & mis;
    assign lsu_o_wb_data  = ((state_q == ST_DONE) & load_q) ? result_q
                                                            : regM_i_alu_result;

endmodule

// File: tb/tb_mem_lsu_ctrl.sv
// Randomized self-checking bench for mem_lsu_ctrl against a byte-level
// transaction model; short timeout so bus errors are reachable.
module tb_mem_lsu_ctrl;
    import lsu_pkg::*;

    localparam int TO = 4;

    logic            clk = 1'b0;
    logic            rst;
    logic [LS_W-1:0] info_i;
    logic [63:0]     alu_i;
    logic [63:0]     rs2_i;
    logic            req_o;
    logic            we_o;
    logic [63:0]     addr_o;
    logic [63:0]     wdata_o;
    logic [7:0]      wstrb_o;
    logic            ack_i;
    logic [63:0]     rdata_i;
    logic            stall_o;
    logic [63:0]     wb_o;
    logic            done_o;
    logic            mis_o;
    logic            berr_o;

    int checks   = 0;
    int failures = 0;

    logic [63:0] obs_addr, obs_wdata, obs_wb;
    logic [7:0]  obs_wstrb;
    logic        obs_we;
    int          obs_stall, obs_req;

    always #5 clk = ~clk;

    mem_lsu_ctrl #(.TIMEOUT_CYCLES(TO), .TO_W(8)) dut (
        .clk                    (clk),
        .rst                    (rst),
        .regM_i_load_store_info (info_i),
        .regM_i_alu_result      (alu_i),
        .regM_i_regdata2        (rs2_i),
        .dcache_o_req           (req_o),
        .dcache_o_we            (we_o),
        .dcache_o_addr          (addr_o),
        .dcache_o_wdata         (wdata_o),
        .dcache_o_wstrb         (wstrb_o),
        .dcache_i_ack           (ack_i),
        .dcache_i_rdata         (rdata_i),
        .lsu_o_stall            (stall_o),
        .lsu_o_wb_data          (wb_o),
        .lsu_o_done             (done_o),
        .lsu_o_misalign         (mis_o),
        .lsu_o_bus_err          (berr_o)
    );

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [63:0] rnd64();
        return {$urandom, $urandom};
    endfunction

    // ---- reference model: bytes and arithmetic ----
    function automatic int m_nbytes(input logic [LS_W-1:0] i);
        if (i[LS_LB] | i[LS_LBU] | i[LS_SB]) return 1;
        if (i[LS_LH] | i[LS_LHU] | i[LS_SH]) return 2;
        if (i[LS_LW] | i[LS_LWU] | i[LS_SW]) return 4;
        return 8;
    endfunction

    function automatic logic [63:0] m_wdata(input logic [63:0] rs2, input int n);
        logic [63:0] w;
        for (int b = 0; b < 8; b++) w[8*b +: 8] = rs2[8*(b % n) +: 8];
        return w;
    endfunction

    function automatic logic [7:0] m_wstrb(input int off, input int n);
        logic [7:0] s;
        for (int b = 0; b < 8; b++) s[b] = (b >= off) && (b < off + n);
        return s;
    endfunction

    function automatic logic [63:0] m_load(input logic [63:0] rd, input int off,
                                           input int n, input logic sgn);
        logic [63:0] v;
        v = '0;
        for (int b = 0; b < n; b++) v[8*b +: 8] = rd[8*(off + b) +: 8];
        if (sgn && n < 8 && v[8*n-1])
            for (int b = n; b < 8; b++) v[8*b +: 8] = 8'hFF;
        return v;
    endfunction

    // Drives one regM op starting just after a posedge; returns just after
    // the posedge that leaves the op's final cycle. lat = REQ cycles before
    // ack (lat >= TO means no ack).
    task automatic run_op(input logic [LS_W-1:0] info, input logic [63:0] ea,
                          input logic [63:0] rs2, input logic [63:0] rd,
                          input int lat);
        int          n, off;
        logic        ld, st, sgn, mis, tmo, hit;
        logic [63:0] exp_wb;
        assert ($onehot0(info));
        n   = m_nbytes(info);
        off = int'(ea[2:0]);
        ld  = |info[LS_LB:LS_LWU];
        st  = |info[LS_SB:LS_SD];
        sgn = info[LS_LB] | info[LS_LH] | info[LS_LW];
        mis = (ld | st) && (off % n != 0);
        tmo = lat >= TO;
        info_i  = info;
        alu_i   = ea;
        rs2_i   = rs2;
        ack_i   = 1'($urandom_range(0, 1));
        rdata_i = rnd64();
        obs_stall = 0;
        obs_req   = 0;
        #1;
        if (!(ld | st)) begin
            chk("nop_stall", stall_o, 0);
            chk("nop_wb", wb_o, ea);
            cyc();
            chk("nop_req", req_o, 0);
            return;
        end
        if (mis) begin
            chk("mis_flag", mis_o, 1);
            chk("mis_stall", stall_o, 0);
            cyc();
            info_i = '0;
            chk("mis_req", req_o, 0);
            chk("mis_done", done_o, 0);
            return;
        end
        chk("idle_mis", mis_o, 0);
        chk("idle_stall", stall_o, 1);
        chk("idle_req", req_o, 0);
        obs_stall += int'(stall_o);
        cyc();
        for (int k = 0; k < TO; k++) begin
            hit     = (k == lat);
            ack_i   = hit;
            rdata_i = hit ? rd : rnd64();
            #1;
            chk("req_req", req_o, 1);
            chk("req_stall", stall_o, 1);
            chk("req_done", done_o, 0);
            chk("req_addr", addr_o, {ea[63:3], 3'b000});
            chk("req_we", we_o, st);
            chk("req_wstrb", wstrb_o, st ? m_wstrb(off, n) : 8'h00);
            if (st) chk("req_wdata", wdata_o, m_wdata(rs2, n));
            obs_stall += int'(stall_o);
            obs_req   += int'(req_o);
            obs_addr  = addr_o;
            obs_wdata = wdata_o;
            obs_wstrb = wstrb_o;
            obs_we    = we_o;
            cyc();
            if (hit) break;
        end
        ack_i   = 1'($urandom_range(0, 1));
        rdata_i = rnd64();
        #1;
        exp_wb = ld ? (tmo ? 64'd0 : m_load(rd, off, n, sgn)) : ea;
        chk("done_done", done_o, 1);
        chk("done_stall", stall_o, 0);
        chk("done_req", req_o, 0);
        chk("done_berr", berr_o, tmo);
        chk("done_wb", wb_o, exp_wb);
        obs_wb = wb_o;
        cyc();
        info_i = '0;
        ack_i  = 1'b0;
        #1;
        chk("after_done", done_o, 0);
        chk("after_req", req_o, 0);
    endtask

    initial begin
        logic [LS_W-1:0] inf;
        logic [63:0]     ea;
        int              r, n;
        rst     = 1'b1;
        info_i  = '0;
        alu_i   = '0;
        rs2_i   = '0;
        ack_i   = 1'b0;
        rdata_i = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_req", req_o, 0);
        chk("rst_we", we_o, 0);
        chk("rst_addr", addr_o, 0);
        chk("rst_wdata", wdata_o, 0);
        chk("rst_wstrb", wstrb_o, 0);
        chk("rst_done", done_o, 0);
        chk("rst_mis", mis_o, 0);
        chk("rst_berr", berr_o, 0);
        chk("rst_stall", stall_o, 0);
        rst = 1'b0;

        run_op(11'b1 << LS_SW, 64'h1004, 64'hDEADBEEF_12345678, rnd64(), 1);
        chk("t1_addr", obs_addr, 64'h1000);
        chk("t1_wdata", obs_wdata, 64'h12345678_12345678);
        chk("t1_wstrb", obs_wstrb, 8'hF0);
        chk("t1_we", obs_we, 1);
        chk("t1_stall_cycles", obs_stall, 3);

        run_op(11'b1 << LS_LB, 64'h2003, 0, 64'h00000000_80000000, 0);
        chk("t2_lb", obs_wb, 64'hFFFFFFFF_FFFFFF80);
        run_op(11'b1 << LS_LBU, 64'h2003, 0, 64'h00000000_80000000, 0);
        chk("t2_lbu", obs_wb, 64'h80);

        run_op(11'b1 << LS_LH, 64'h3001, 0, 0, 0);

        run_op(11'b1 << LS_LD, 64'h4000, 0, rnd64(), 99);
        chk("t4_req_cycles", obs_req, TO);
        chk("t4_wb", obs_wb, 0);

        run_op(11'b1 << LS_LW, 64'h5004, 0, 64'h87654321_00000000, TO - 1);
        chk("ack_at_timeout", obs_wb, 64'hFFFFFFFF_87654321);

        // reset during REQ, late ack must be ignored
        info_i = 11'b1 << LS_LD;
        alu_i  = 64'h6000;
        cyc();
        chk("t5_in_req", req_o, 1);
        rst = 1'b1;
        cyc();
        rst    = 1'b0;
        info_i = '0;
        ack_i  = 1'b1;
        #1;
        chk("t5_req", req_o, 0);
        chk("t5_done", done_o, 0);
        chk("t5_stall", stall_o, 0);
        cyc();
        ack_i = 1'b0;
        chk("t5_req2", req_o, 0);
        chk("t5_done2", done_o, 0);

        run_op(11'b1 << LS_SD, 64'h7008, 64'h01234567_89ABCDEF, rnd64(), 0);
        chk("t6_sd_req", obs_req, 1);
        run_op(11'b1 << LS_LWU, 64'h7014, 0, 64'hF00DCAFE_00000000, 0);
        chk("t6_lwu_req", obs_req, 1);
        chk("t6_lwu", obs_wb, 64'h00000000_F00DCAFE);

        for (int i = 0; i < 300; i++) begin
            r   = $urandom_range(0, 11);
            inf = (r == 11) ? '0 : (11'b1 << r);
            n   = m_nbytes(inf);
            ea  = rnd64();
            if ($urandom_range(0, 3) != 0)
                ea[2:0] = ea[2:0] & ~3'(n - 1);
            run_op(inf, ea, rnd64(), rnd64(), $urandom_range(0, TO + 1));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1);
    end

endmodule
